// File: rtl/neo_pkg.sv
// Shared types and defaults for the double-buffered NeoPixel strand driver.
// The optional per-frame brightness scaler is enabled with `define NEO_BRIGHTNESS_EN.
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_HIGH = 2'd1,
    BIT_LOW  = 2'd2,
    LATCH    = 2'd3
  } neo_state_e;

  // Default geometry and WS2812 timing at a 50 MHz clock.
  localparam int DEF_NUM_PIXELS   = 8;
  localparam int DEF_NUM_CHANNELS = 3;
  localparam int DEF_COLOR_BITS   = 8;
  localparam int DEF_T0H          = 20;
  localparam int DEF_T1H          = 40;
  localparam int DEF_T_BIT        = 63;
  localparam int DEF_T_RESET      = 2500;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// One-wire bit cell generator: on start, drives the line high for T0H/T1H
// cycles, low for the rest of T_BIT, and pulses done on the last cycle.
module neo_bit_encoder
  import neo_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int T_BIT = DEF_T_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic bit_i,
  output logic line_o,
  output logic fall_o,
  output logic done_o
);

  localparam int CNT_W = width_of(T_BIT);
  localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);

  logic             active_q, active_d;
  logic             bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_last;

  always_comb begin
    high_last = bit_q ? T1H_LAST : T0H_LAST;
    line_o    = active_q && (cnt_q <= high_last);
    fall_o    = active_q && (cnt_q == high_last);
    done_o    = active_q && (cnt_q == BIT_LAST);
  end

  // A start on the done cycle restarts the cell with no idle gap between bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      bit_d    = bit_i;
      cnt_d    = '0;
    end else if (done_o) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/neo_strand_ctrl.sv
// Double-buffered NeoPixel strand driver: frame buffer written by the host, shadow
// snapshot serialised MSB-first then latched low. `define NEO_BRIGHTNESS_EN adds scaling.
module neo_strand_ctrl
  import neo_pkg::*;
#(
  parameter int  NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int  NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int  COLOR_BITS   = DEF_COLOR_BITS,
  parameter int  T0H          = DEF_T0H,
  parameter int  T1H          = DEF_T1H,
  parameter int  T_BIT        = DEF_T_BIT,
  parameter int  T_RESET      = DEF_T_RESET,
  localparam int PIX_W        = width_of(NUM_PIXELS),
  localparam int CH_W         = width_of(NUM_CHANNELS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PIX_W-1:0]      pixel_index,
  input  logic [CH_W-1:0]       color_index,
  input  logic [COLOR_BITS-1:0] color_level,
  input  logic                  load_color,
  input  logic                  send_it,
`ifdef NEO_BRIGHTNESS_EN
  input  logic [COLOR_BITS-1:0] brightness,
`endif
  output logic                  neo_data,
  output logic                  ready_to_load,
  output logic                  ready_to_send,
  output logic                  busy
);

  localparam int BIT_W   = width_of(COLOR_BITS);
  localparam int LATCH_W = width_of(T_RESET);

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [BIT_W-1:0]   BIT_MSB    = BIT_W'(COLOR_BITS - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(T_RESET - 1);

  typedef logic [NUM_PIXELS-1:0][NUM_CHANNELS-1:0][COLOR_BITS-1:0] frame_t;

  neo_state_e           state_q, state_d;
  frame_t               frame_q, frame_d;
  frame_t               shadow_q, shadow_d;
  logic [PIX_W-1:0]     pix_q, pix_d, pix_nx;
  logic [CH_W-1:0]      ch_q, ch_d, ch_nx;
  logic [BIT_W-1:0]     bit_q, bit_d, bit_nx;
  logic [LATCH_W-1:0]   latch_q, latch_d;
  logic                 accept;
  logic                 last_bit;
  logic                 wr_in_range;
  logic [COLOR_BITS-1:0] sel_level;
  logic [COLOR_BITS-1:0] tx_level;
  logic [BIT_W-1:0]     sel_bit;
  logic                 enc_start, enc_bit;
  logic                 enc_line, enc_fall, enc_done;

`ifdef NEO_BRIGHTNESS_EN
  localparam int PROD_W = 2 * COLOR_BITS;
  logic [COLOR_BITS-1:0] bright_q, bright_d;
  logic [COLOR_BITS-1:0] sel_bright;
  logic [PROD_W-1:0]     product;
`endif

  assign ready_to_load = 1'b1;
  assign accept        = (state_q == IDLE) && send_it;
  assign wr_in_range   = (int'(pixel_index) < NUM_PIXELS) && (int'(color_index) < NUM_CHANNELS);
  assign last_bit      = (pix_q == PIX_LAST) && (ch_q == CH_LAST) && (bit_q == '0);

  // frame_d is also the snapshot source, so a write on the accept edge is captured.
  always_comb begin
    frame_d = frame_q;
    if (load_color && wr_in_range) begin
      frame_d[pixel_index][color_index] = color_level;
    end
  end

  always_comb begin
    bit_nx = bit_q - BIT_W'(1);
    ch_nx  = ch_q;
    pix_nx = pix_q;
    if (bit_q == '0) begin
      bit_nx = BIT_MSB;
      if (ch_q == CH_LAST) begin
        ch_nx  = '0;
        pix_nx = pix_q + PIX_W'(1);
      end else begin
        ch_nx = ch_q + CH_W'(1);
      end
    end
  end

  // Level feeding the encoder on its next start: first bit of the new snapshot on
  // accept, otherwise the following bit of the shadow buffer.
  always_comb begin
    sel_level = accept ? frame_d[0][0] : shadow_q[pix_nx][ch_nx];
    sel_bit   = accept ? BIT_MSB : bit_nx;
`ifdef NEO_BRIGHTNESS_EN
    sel_bright = accept ? brightness : bright_q;
    product    = PROD_W'(sel_level) * (PROD_W'(sel_bright) + PROD_W'(1));
    tx_level   = COLOR_BITS'(product >> COLOR_BITS);
`else
    tx_level   = sel_level;
`endif
    enc_bit = tx_level[sel_bit];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    pix_d     = pix_q;
    ch_d      = ch_q;
    bit_d     = bit_q;
    latch_d   = latch_q;
    enc_start = 1'b0;
`ifdef NEO_BRIGHTNESS_EN
    bright_d  = bright_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (send_it) begin
          state_d   = BIT_HIGH;
          shadow_d  = frame_d;
          pix_d     = '0;
          ch_d      = '0;
          bit_d     = BIT_MSB;
          enc_start = 1'b1;
`ifdef NEO_BRIGHTNESS_EN
          bright_d  = brightness;
`endif
        end
      end
      BIT_HIGH: begin
        if (enc_fall) state_d = BIT_LOW;
      end
      BIT_LOW: begin
        if (enc_done) begin
          if (last_bit) begin
            state_d = LATCH;
            latch_d = '0;
          end else begin
            state_d   = BIT_HIGH;
            pix_d     = pix_nx;
            ch_d      = ch_nx;
            bit_d     = bit_nx;
            enc_start = 1'b1;
          end
        end
      end
      LATCH: begin
        if (latch_q == LATCH_LAST) state_d = IDLE;
        else                       latch_d = latch_q + LATCH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    neo_data      = 1'b0;
    ready_to_send = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE: begin
        ready_to_send = 1'b1;
        busy          = 1'b0;
      end
      BIT_HIGH, BIT_LOW: neo_data = enc_line;
      default:           neo_data = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: both buffers are reset because a fresh frame after reset must be all zeros.
    if (!reset_n) begin
      frame_q  <= '0;
      shadow_q <= '0;
      pix_q    <= '0;
      ch_q     <= '0;
      bit_q    <= '0;
      latch_q  <= '0;
`ifdef NEO_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      pix_q    <= pix_d;
      ch_q     <= ch_d;
      bit_q    <= bit_d;
      latch_q  <= latch_d;
`ifdef NEO_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  neo_bit_encoder #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT)
  ) u_encoder (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (enc_start),
    .bit_i   (enc_bit),
    .line_o  (enc_line),
    .fall_o  (enc_fall),
    .done_o  (enc_done)
  );

endmodule

// File: tb/tb_neo_strand_ctrl.sv
// Directed bench for neo_strand_ctrl at default parameters; the brightness scenario
// is built only when NEO_BRIGHTNESS_EN is defined.
module tb_neo_strand_ctrl;

  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int T_BIT  = 63;
  localparam int NBITS  = 8 * 3 * 8;
  localparam int FRAME  = NBITS * T_BIT + 2500;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_color;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       busy;
`ifdef NEO_BRIGHTNESS_EN
  logic [7:0] brightness;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] cap    [8][3];
  logic [7:0] exp_lv [8][3];
  int         cap_bad;
  int         cap_busy;

  always #5 clock = ~clock;

  neo_strand_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .send_it       (send_it),
`ifdef NEO_BRIGHTNESS_EN
    .brightness    (brightness),
`endif
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .busy          (busy)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_px(input int p, input int c, input logic [7:0] v);
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = v;
    load_color  = 1'b1;
    step();
    load_color  = 1'b0;
  endtask

  // Starts on the first cycle after the accept edge; decodes nbits cells by high
  // time and, if to_idle, keeps counting busy cycles until busy drops.
  task automatic capture(input int nbits, input bit to_idle);
    int  hc;
    bit  seen_low;
    cap_bad  = 0;
    cap_busy = 0;
    foreach (cap[p, c]) cap[p][c] = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      hc       = 0;
      seen_low = 1'b0;
      for (int t = 0; t < T_BIT; t++) begin
        if (neo_data === 1'b1) begin
          if (seen_low) cap_bad++;
          hc++;
        end else begin
          seen_low = 1'b1;
        end
        if (busy === 1'b1) cap_busy++;
        step();
      end
      if (hc == T1H)      cap[b / 24][(b / 8) % 3][7 - (b % 8)] = 1'b1;
      else if (hc != T0H) cap_bad++;
    end
    if (to_idle) begin
      while (busy === 1'b1 && cap_busy < 20000) begin
        cap_busy++;
        step();
      end
    end
  endtask

  task automatic clear_expected();
    foreach (exp_lv[p, c]) exp_lv[p][c] = 8'h00;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    load_color  = 1'b0;
    send_it     = 1'b0;
`ifdef NEO_BRIGHTNESS_EN
    brightness  = 8'hFF;
`endif
    repeat (3) step();
    checks++; if (neo_data !== 1'b0)      begin errors++; $display("FAIL reset_neo_data: got %b expected 0", neo_data); end
    checks++; if (ready_to_send !== 1'b1) begin errors++; $display("FAIL reset_ready_to_send: got %b expected 1", ready_to_send); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready_to_load !== 1'b1) begin errors++; $display("FAIL reset_ready_to_load: got %b expected 1", ready_to_load); end
    reset_n = 1'b1;
    repeat (20) step();
    checks++; if (neo_data !== 1'b0 || busy !== 1'b0 || ready_to_send !== 1'b1) begin
      errors++; $display("FAIL idle_outputs: got neo_data=%b busy=%b ready_to_send=%b expected 0 0 1", neo_data, busy, ready_to_send);
    end
  endtask

  // Frame 1 carries 0x80 in pixel 0 ch 0; a mid-frame write of A5 must only show in
  // frame 2, which starts on its own because send_it stays high.
  task automatic test_back_to_back();
    write_px(0, 0, 8'h80);
    send_it = 1'b1;
    step();
    checks++; if (neo_data !== 1'b1 || busy !== 1'b1 || ready_to_send !== 1'b0) begin
      errors++; $display("FAIL f1_latency: got neo_data=%b busy=%b ready_to_send=%b expected 1 1 0", neo_data, busy, ready_to_send);
    end
    fork
      capture(NBITS, 1'b1);
      begin
        repeat (10) step();
        checks++; if (ready_to_load !== 1'b1) begin errors++; $display("FAIL busy_ready_to_load: got %b expected 1", ready_to_load); end
        write_px(3, 2, 8'hA5);
      end
    join
    clear_expected();
    exp_lv[0][0] = 8'h80;
    foreach (exp_lv[p, c]) begin
      checks++;
      if (cap[p][c] !== exp_lv[p][c]) begin
        errors++; $display("FAIL f1_level p%0d c%0d: got %h expected %h", p, c, cap[p][c], exp_lv[p][c]);
      end
    end
    checks++; if (cap_bad != 0)       begin errors++; $display("FAIL f1_waveform: got %0d bad cells expected 0", cap_bad); end
    checks++; if (cap_busy != FRAME)  begin errors++; $display("FAIL f1_busy_len: got %0d expected %0d", cap_busy, FRAME); end
    checks++; if (ready_to_send !== 1'b1 || neo_data !== 1'b0) begin
      errors++; $display("FAIL f1_idle: got ready_to_send=%b neo_data=%b expected 1 0", ready_to_send, neo_data);
    end
    step();
    checks++; if (neo_data !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL f2_restart: got neo_data=%b busy=%b expected 1 1", neo_data, busy);
    end
    send_it = 1'b0;
    capture(NBITS, 1'b1);
    exp_lv[3][2] = 8'hA5;
    foreach (exp_lv[p, c]) begin
      checks++;
      if (cap[p][c] !== exp_lv[p][c]) begin
        errors++; $display("FAIL f2_level p%0d c%0d: got %h expected %h", p, c, cap[p][c], exp_lv[p][c]);
      end
    end
    checks++; if (cap_bad != 0)      begin errors++; $display("FAIL f2_waveform: got %0d bad cells expected 0", cap_bad); end
    checks++; if (cap_busy != FRAME) begin errors++; $display("FAIL f2_busy_len: got %0d expected %0d", cap_busy, FRAME); end
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL f2_no_retrigger: got busy=%b expected 0", busy); end
  endtask

  // Out-of-range channel write is dropped; a write on the accept cycle is in the frame.
  task automatic test_write_through();
    write_px(1, 3, 8'h5A);
    pixel_index = 3'd0;
    color_index = 2'd0;
    color_level = 8'hFF;
    load_color  = 1'b1;
    send_it     = 1'b1;
    step();
    load_color  = 1'b0;
    send_it     = 1'b0;
    capture(NBITS, 1'b1);
    clear_expected();
    exp_lv[0][0] = 8'hFF;
    exp_lv[3][2] = 8'hA5;
    foreach (exp_lv[p, c]) begin
      checks++;
      if (cap[p][c] !== exp_lv[p][c]) begin
        errors++; $display("FAIL wt_level p%0d c%0d: got %h expected %h", p, c, cap[p][c], exp_lv[p][c]);
      end
    end
    checks++; if (cap_bad != 0)      begin errors++; $display("FAIL wt_waveform: got %0d bad cells expected 0", cap_bad); end
    checks++; if (cap_busy != FRAME) begin errors++; $display("FAIL wt_busy_len: got %0d expected %0d", cap_busy, FRAME); end
  endtask

  task automatic test_reset_mid_frame();
    send_it = 1'b1;
    step();
    send_it = 1'b0;
    repeat (504) step();
    checks++; if (neo_data !== 1'b1) begin errors++; $display("FAIL mid_high_before_reset: got %b expected 1", neo_data); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (neo_data !== 1'b0 || busy !== 1'b0 || ready_to_send !== 1'b1) begin
      errors++; $display("FAIL mid_async_reset: got neo_data=%b busy=%b ready_to_send=%b expected 0 0 1", neo_data, busy, ready_to_send);
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    send_it = 1'b1;
    step();
    send_it = 1'b0;
    capture(NBITS, 1'b1);
    clear_expected();
    foreach (exp_lv[p, c]) begin
      checks++;
      if (cap[p][c] !== exp_lv[p][c]) begin
        errors++; $display("FAIL post_reset_level p%0d c%0d: got %h expected %h", p, c, cap[p][c], exp_lv[p][c]);
      end
    end
    checks++; if (cap_bad != 0)      begin errors++; $display("FAIL post_reset_waveform: got %0d bad cells expected 0", cap_bad); end
    checks++; if (cap_busy != FRAME) begin errors++; $display("FAIL post_reset_busy_len: got %0d expected %0d", cap_busy, FRAME); end
  endtask

`ifdef NEO_BRIGHTNESS_EN
  // Brightness is taken on the accept edge; changing it mid-frame must not matter.
  task automatic test_brightness();
    logic [7:0] exp_scaled [2] = '{8'h64, 8'hC8};
    logic [7:0] bright_in  [2] = '{8'h7F, 8'hFF};
    for (int k = 0; k < 2; k++) begin
      write_px(0, 0, 8'hC8);
      brightness = bright_in[k];
      send_it    = 1'b1;
      step();
      send_it    = 1'b0;
      brightness = ~bright_in[k];
      capture(8, 1'b0);
      checks++; if (cap[0][0] !== exp_scaled[k] || cap_bad != 0) begin
        errors++; $display("FAIL brightness_%0d: got %h (bad cells %0d) expected %h", k, cap[0][0], cap_bad, exp_scaled[k]);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
    end
    brightness = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_write_through();
    test_reset_mid_frame();
`ifdef NEO_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
